// File: rtl/uart_rx_fifo.sv
// Receive-side buffer for the UART receiver: drives the receiver's go line and
// stores each delivered byte in a first-word-fall-through FIFO for the CPU.
module uart_rx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               uart_data,
  input  logic                     uart_dr,
  output logic                     uart_go,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            go_q, go_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      mem_q [DEPTH];
  logic            push, pop;

  // A byte is accepted only while armed; ARM is entered only with free space.
  assign push     = (state_q == ARM) && uart_dr;
  assign rd_valid = (count_q != '0);
  assign pop      = rd_en && rd_valid;

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // Arming looks at the occupancy after this edge, so a pop out of full
  // re-arms on the same edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!uart_dr && (count_d < CW'(DEPTH))) state_d = ARM;
      ARM:     if (uart_dr) state_d = DRAIN;
      DRAIN:   if (!uart_dr) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    go_d = (state_d == ARM);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      go_q     <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      go_q     <= go_d;
      count_q  <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: the storage array has no reset; contents are only visible through
  // rd_data when count says they were written, and leaving it out keeps the
  // array mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= uart_data;
  end

  assign rd_data = rd_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign uart_go = go_q;
  assign count   = count_q;

endmodule
